// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size encodings, FSM states and lane-mask helper
package mem_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Byte lanes touched by an access of the given size at the given offset
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        base = size == SZ_BYTE ? 8'h01 : size == SZ_HALF ? 8'h03 : size == SZ_WORD ? 8'h0F : 8'hFF;
        return base << offset;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: shifts the addressed bytes of a word down and sign/zero-extends them
module load_align
    import mem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int OW         = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [OW-1:0]         offset,
    input  logic [1:0]            size,
    input  logic                  uns,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep;
    logic                  sbit;

    // Keep the low bytes of the size, fill the rest with the sign bit or zero
    always_comb begin
        shifted = word >> {offset, 3'b000};
        keep    = size == SZ_BYTE ? DATA_WIDTH'(8'hFF) :
                  size == SZ_HALF ? DATA_WIDTH'(16'hFFFF) :
                  size == SZ_WORD ? DATA_WIDTH'(32'hFFFF_FFFF) : '1;
        sbit    = ~uns & (size == SZ_BYTE ? shifted[7] :
                          size == SZ_HALF ? shifted[15] :
                          size == SZ_WORD ? shifted[31] : 1'b0);
        result  = (shifted & keep) | ({DATA_WIDTH{sbit}} & ~keep);
    end

endmodule

// File: rtl/data_memory.sv
// data_memory: byte-addressable load/store memory with wait states and fault reporting
module data_memory
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OW    = $clog2(LANES);
    localparam int IW    = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    state_t                state;
    logic [3:0]            cnt;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] widx;
    logic [OW-1:0]         off;
    logic                  fault_now;
    logic [LANES-1:0]      wmask;
    logic [DATA_WIDTH-1:0] wsh;
    logic [DATA_WIDTH-1:0] rword;
    logic [DATA_WIDTH-1:0] aligned;
    logic                  r_we;
    logic                  r_fault;
    logic                  r_uns;
    logic [1:0]            r_size;
    logic [OW-1:0]         r_off;

    assign accept = state == IDLE && req_valid;
    assign widx   = req_addr >> OW;
    assign off    = req_addr[OW-1:0];
    assign wmask  = LANES'(lane_mask(req_size, 3'(off)));
    assign wsh    = req_wdata << {off, 3'b000};

    // Misalignment, an illegal double on a 32-bit memory, or an index past the end
    always_comb begin
        fault_now = (req_size == SZ_HALF && req_addr[0]) ||
                    (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
                    (req_size == SZ_DOUBLE && (req_addr[2:0] != 3'b000 || DATA_WIDTH == 32)) ||
                    (widx >= ADDR_WIDTH'(MEM_DEPTH));
    end

    // Storage is never reset: commit selected store lanes and capture the load word at acceptance
    always_ff @(posedge clk) begin
        if (!rst && accept && req_we && !fault_now)
            for (int k = 0; k < LANES; k++)
                if (wmask[k])
                    mem[widx[IW-1:0]][k*8 +: 8] <= wsh[k*8 +: 8];
        if (accept)
            rword <= mem[widx[IW-1:0]];
    end

    // Handshake FSM: latch request fields on acceptance, count wait states, pulse response
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            r_we    <= 1'b0;
            r_fault <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= SZ_BYTE;
            r_off   <= '0;
        end else if (accept) begin
            state   <= WAIT_STATES > 0 ? WAIT : RESP;
            cnt     <= '0;
            r_we    <= req_we;
            r_fault <= fault_now;
            r_uns   <= req_unsigned;
            r_size  <= req_size;
            r_off   <= off;
        end else if (state == WAIT) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'(WAIT_STATES - 1))
                state <= RESP;
        end else if (state == RESP) begin
            state <= IDLE;
        end
    end

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .word   (rword),
        .offset (r_off),
        .size   (r_size),
        .uns    (r_uns),
        .result (aligned)
    );

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign resp_fault = resp_valid && r_fault;
    assign resp_rdata = (resp_valid && !r_we && !r_fault) ? aligned : '0;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed checks of data_memory in 32-bit/0-wait, 32-bit/3-wait and 64-bit builds
module tb_data_memory;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  v;
    logic        we, un;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [63:0] wd;
    logic [2:0]  rdy, rv, fl;
    logic [31:0] rd0, rd3;
    logic [63:0] rd64;
    int          vectors = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    data_memory #(.DATA_WIDTH(32), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .req_valid(v[0]), .req_ready(rdy[0]), .req_we(we),
        .req_size(sz), .req_unsigned(un), .req_addr(a), .req_wdata(wd[31:0]),
        .resp_valid(rv[0]), .resp_rdata(rd0), .resp_fault(fl[0])
    );

    data_memory #(.DATA_WIDTH(32), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .req_valid(v[1]), .req_ready(rdy[1]), .req_we(we),
        .req_size(sz), .req_unsigned(un), .req_addr(a), .req_wdata(wd[31:0]),
        .resp_valid(rv[1]), .resp_rdata(rd3), .resp_fault(fl[1])
    );

    data_memory #(.DATA_WIDTH(64), .WAIT_STATES(0)) u64 (
        .clk(clk), .rst(rst), .req_valid(v[2]), .req_ready(rdy[2]), .req_we(we),
        .req_size(sz), .req_unsigned(un), .req_addr(a), .req_wdata(wd),
        .resp_valid(rv[2]), .resp_rdata(rd64), .resp_fault(fl[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input int sel, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] ad, input logic [63:0] d,
                        output logic [63:0] r, output logic f, output int lat);
        int n;
        @(negedge clk);
        we = w; sz = s; un = u; a = ad; wd = d; v[sel] = 1'b1;
        n = 0;
        while (!rdy[sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        v[sel] = 1'b0;
        lat = 1;
        while (!rv[sel] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        r = sel == 0 ? {32'b0, rd0} : sel == 1 ? {32'b0, rd3} : rd64;
        f = fl[sel];
    endtask

    initial begin
        logic [63:0] r;
        logic        f;
        int          lat, lowc, rvat, seen;
        logic [31:0] got;
        rst = 1'b1; v = '0; we = 1'b0; un = 1'b0; sz = SZ_BYTE; a = '0; wd = '0;
        repeat (2) @(negedge clk);
        check("reset ready", 64'(rdy), 64'h7);
        check("reset valid", 64'(rv), 64'h0);
        check("reset fault", 64'(fl), 64'h0);
        check("reset rdata", {rd3, rd0}, 64'h0);
        rst = 1'b0;

        xact(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 64'hDEADBEEF, r, f, lat);
        check("st word fault", 64'(f), 64'h0);
        check("st word rdata", r, 64'h0);
        xact(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 64'h0, r, f, lat);
        check("ld word latency", 64'(lat), 64'd1);
        check("ld word rdata", r, 64'hDEADBEEF);
        check("ld word fault", 64'(f), 64'h0);
        @(negedge clk);
        check("resp pulse width", 64'(rv[0]), 64'h0);
        check("rdata hold zero", 64'(rd0), 64'h0);

        xact(0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 64'h80, r, f, lat);
        xact(0, 1'b0, SZ_BYTE, 1'b0, 32'h11, 64'h0, r, f, lat);
        check("ld byte signed", r, 64'hFFFFFF80);
        xact(0, 1'b0, SZ_BYTE, 1'b1, 32'h11, 64'h0, r, f, lat);
        check("ld byte unsigned", r, 64'h00000080);
        xact(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 64'h0, r, f, lat);
        check("ld word merged", r, 64'hDEAD80EF);
        xact(0, 1'b0, SZ_HALF, 1'b0, 32'h12, 64'h0, r, f, lat);
        check("ld half signed", r, 64'hFFFFDEAD);

        xact(0, 1'b0, SZ_HALF, 1'b0, 32'h13, 64'h0, r, f, lat);
        check("misaligned half fault", 64'(f), 64'h1);
        check("misaligned half rdata", r, 64'h0);
        xact(0, 1'b1, SZ_WORD, 1'b0, 32'h4002, 64'h12345678, r, f, lat);
        check("oob store fault", 64'(f), 64'h1);
        xact(0, 1'b0, SZ_WORD, 1'b0, 32'h4000, 64'h0, r, f, lat);
        check("oob load fault", 64'(f), 64'h1);
        check("oob load rdata", r, 64'h0);
        xact(0, 1'b1, SZ_WORD, 1'b0, 32'h0, 64'h55AA55AA, r, f, lat);
        xact(0, 1'b1, SZ_WORD, 1'b0, 32'h1000, 64'h12345678, r, f, lat);
        check("oob aligned store fault", 64'(f), 64'h1);
        xact(0, 1'b0, SZ_WORD, 1'b0, 32'h0, 64'h0, r, f, lat);
        check("oob store no write", r, 64'h55AA55AA);
        xact(0, 1'b0, SZ_DOUBLE, 1'b0, 32'h10, 64'h0, r, f, lat);
        check("double on 32 fault", 64'(f), 64'h1);
        check("double on 32 rdata", r, 64'h0);

        xact(1, 1'b1, SZ_WORD, 1'b0, 32'h10, 64'h11112222, r, f, lat);
        check("w3 store latency", 64'(lat), 64'd4);
        xact(1, 1'b1, SZ_WORD, 1'b0, 32'h14, 64'h33334444, r, f, lat);
        @(negedge clk);
        we = 1'b0; sz = SZ_WORD; un = 1'b0; a = 32'h10; v[1] = 1'b1;
        @(posedge clk);
        for (int q = 0; q < 2; q++) begin
            lowc = 0; rvat = 0; got = '0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (i == 1) a = 32'h14;
                if (rv[1]) begin
                    rvat = i;
                    got = rd3;
                end
                if (rdy[1]) break;
                lowc++;
            end
            check($sformatf("b2b%0d ready low cycles", q), 64'(lowc), 64'd4);
            check($sformatf("b2b%0d resp cycle", q), 64'(rvat), 64'd4);
            check($sformatf("b2b%0d rdata", q), 64'(got), q == 0 ? 64'h11112222 : 64'h33334444);
        end
        v[1] = 1'b0;

        @(negedge clk);
        we = 1'b0; sz = SZ_WORD; a = 32'h10; v[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v[1] = 1'b0;
        check("in wait ready low", 64'(rdy[1]), 64'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ready after reset", 64'(rdy[1]), 64'h1);
        seen = 0;
        repeat (6) begin
            if (rv[1]) seen++;
            @(negedge clk);
        end
        check("dropped response", 64'(seen), 64'h0);
        xact(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 64'h0, r, f, lat);
        check("data survives reset", r, 64'h11112222);

        xact(2, 1'b1, SZ_DOUBLE, 1'b0, 32'h8, 64'h0123456789ABCDEF, r, f, lat);
        check("st double fault", 64'(f), 64'h0);
        xact(2, 1'b0, SZ_HALF, 1'b0, 32'hE, 64'h0, r, f, lat);
        check("64 ld half signed", r, 64'h0000000000000123);
        xact(2, 1'b0, SZ_DOUBLE, 1'b0, 32'h8, 64'h0, r, f, lat);
        check("64 ld double", r, 64'h0123456789ABCDEF);
        xact(2, 1'b0, SZ_BYTE, 1'b0, 32'hB, 64'h0, r, f, lat);
        check("64 ld byte signed", r, 64'hFFFFFFFFFFFFFF89);
        xact(2, 1'b0, SZ_WORD, 1'b1, 32'hC, 64'h0, r, f, lat);
        check("64 ld word unsigned", r, 64'h0000000001234567);
        xact(2, 1'b0, SZ_DOUBLE, 1'b0, 32'hC, 64'h0, r, f, lat);
        check("64 misaligned double", 64'(f), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
